// File: rtl/cft_irq_defs_pkg.sv
// Shared definitions for the IRQ arbiter: register addresses, FSM states,
// default vector base and a one-hot helper.
package cft_irq_defs;

   localparam logic [1:0] IRQ_MASK = 2'd0;
   localparam logic [1:0] IRQ_PEND = 2'd1;
   localparam logic [1:0] IRQ_INSV = 2'd2;
   localparam logic [1:0] IRQ_VEC  = 2'd3;

   localparam logic [15:0] VEC_BASE_DEF = 16'h0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } irq_state_e;

   function automatic logic [7:0] onehot3(input logic [2:0] idx);
      return 8'(1) << idx;
   endfunction

endpackage

// File: rtl/irq_prienc8.sv
// Combinational 8-bit priority encoder: lowest set index wins, o_vld flags any set.
module irq_prienc8 (
   input  logic [7:0] i_vec,
   output logic [2:0] o_idx,
   output logic       o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      // Scan downwards so the lowest set bit is the last assignment.
      for (int i = 7; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = 3'(i);
            o_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter for the eight extended IRQ lines feeding the ISM nirq input.
// Define IRQ_ARB_NESTING_EN to let a higher-priority line preempt the level in service.
module irq_arbiter
   import cft_irq_defs::*;
#(
   parameter int          NLINES      = 8,
   parameter logic [15:0] VEC_BASE    = VEC_BASE_DEF,
   parameter int          SYNC_STAGES = 2
) (
   input  logic              clk4,
   input  logic              nreset,
   input  logic [NLINES-1:0] nirqn,
   input  logic              nirqs,
   output logic              nirq,
   input  logic              nsel,
   input  logic              nw,
   input  logic              nr,
   input  logic [1:0]        ab,
   input  logic [15:0]       db_in,
   output logic [15:0]       db_out,
   output logic              db_oe
);

   logic [SYNC_STAGES-1:0][NLINES-1:0] r_sync;
   logic [NLINES-1:0] r_line_prev;
   logic [NLINES-1:0] r_mask, r_pend, r_insv;
   logic [15:0]       r_vec;
   logic [15:0]       r_db_out;
   logic              r_nw_prev;
   irq_state_e        r_state, w_state_nx;

   logic [NLINES-1:0] w_line, w_fall, w_req;
   logic [NLINES-1:0] w_w1c, w_ack_clr, w_eoi_clr;
   logic [2:0]        w_win_idx, w_cur_idx;
   logic              w_win_vld, w_cur_vld;
   logic              w_elig, w_go, w_ack;
   logic              w_wr, w_wr_mask, w_wr_pend, w_wr_vec;
   logic [15:0]       w_rd_data;
   logic              w_unused;

   assign w_unused = &{1'b0, db_in[15:8]};

   // Input synchronisers and falling-edge detect on the synchronised lines.
   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_sync      <= '1;
         r_line_prev <= '1;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], nirqn};
         r_line_prev <= w_line;
      end
   end

   assign w_line = r_sync[SYNC_STAGES-1];
   assign w_fall = r_line_prev & ~w_line;

   assign w_req = r_pend & ~r_mask;

   irq_prienc8 u_win (.i_vec(w_req),  .o_idx(w_win_idx), .o_vld(w_win_vld));
   irq_prienc8 u_cur (.i_vec(r_insv), .o_idx(w_cur_idx), .o_vld(w_cur_vld));

`ifdef IRQ_ARB_NESTING_EN
   assign w_elig = ~w_cur_vld | (w_win_idx < w_cur_idx);
`else
   assign w_elig = ~w_cur_vld;
`endif
   assign w_go = w_win_vld & w_elig;

   // One write per strobe: only the first edge of a low nw counts.
   assign w_wr      = ~nsel & ~nw & r_nw_prev;
   assign w_wr_mask = w_wr & (ab == IRQ_MASK);
   assign w_wr_pend = w_wr & (ab == IRQ_PEND);
   assign w_wr_vec  = w_wr & (ab == IRQ_VEC);

   always_comb begin
      w_state_nx = r_state;
      w_ack      = 1'b0;
      case (r_state)
         ST_IDLE: if (w_go) w_state_nx = ST_REQ;
         ST_REQ: begin
            if (!w_go) begin
               w_state_nx = ST_IDLE;
            end else if (!nirqs) begin
               w_ack      = 1'b1;
               w_state_nx = ST_ACK;
            end
         end
         ST_ACK:  if (nirqs) w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase
   end

   assign w_w1c     = w_wr_pend ? db_in[NLINES-1:0] : '0;
   assign w_ack_clr = w_ack ? onehot3(w_win_idx) : '0;
   assign w_eoi_clr = (w_wr_vec && w_cur_vld) ? onehot3(w_cur_idx) : '0;

   // Clears are applied before sets so a coincident new edge keeps its pending bit.
   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) begin
         r_state   <= ST_IDLE;
         r_mask    <= '1;
         r_pend    <= '0;
         r_insv    <= '0;
         r_vec     <= VEC_BASE;
         r_nw_prev <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_nw_prev <= nw;
         r_pend    <= (r_pend & ~w_w1c & ~w_ack_clr) | w_fall;
         r_insv    <= (r_insv & ~w_eoi_clr) | w_ack_clr;
         if (w_wr_mask) r_mask <= db_in[NLINES-1:0];
         if (w_ack)     r_vec  <= VEC_BASE | {13'b0, w_win_idx};
      end
   end

   always_comb begin
      w_rd_data = '0;
      case (ab)
         IRQ_MASK: w_rd_data = {8'h00, r_mask};
         IRQ_PEND: w_rd_data = {8'h00, r_pend};
         IRQ_INSV: w_rd_data = {8'h00, r_insv};
         default:  w_rd_data = r_vec;
      endcase
   end

   always_ff @(posedge clk4 or negedge nreset) begin
      if (!nreset) r_db_out <= '0;
      else         r_db_out <= (!nsel && !nr) ? w_rd_data : '0;
   end

   assign db_out = r_db_out;
   assign db_oe  = ~nsel & ~nr;
   assign nirq   = (r_state != ST_REQ);

endmodule
